// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one non-pipelined fixed-latency word memory between the IF and DM ports
module mem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_valid,
    output logic              o_stall_if,
    output logic              o_stall_mem,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_dm;
    logic              r_last_dm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [3:0]        r_cnt;
    logic              w_grant;
    logic              w_grant_dm;
    logic              w_last;

    // next state, grant choice (DM wins a conflict unless it won the previous one) and strobes
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grant_dm = 1'b0;
        w_last     = 1'b0;
        o_mem_en   = 1'b0;
        o_if_valid = 1'b0;
        o_dm_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant    = i_if_req | i_dm_req;
                w_grant_dm = i_dm_req & (~i_if_req | ~r_last_dm);
                w_next     = w_grant ? ISSUE : IDLE;
            end
            ISSUE: begin
                o_mem_en = 1'b1;
                w_next   = WAIT;
            end
            WAIT: begin
                w_last = (r_cnt == 4'd0);
                w_next = w_last ? DONE : WAIT;
            end
            DONE: begin
                o_if_valid = ~r_owner_dm;
                o_dm_valid = r_owner_dm;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // grant latch, latency countdown and read-data capture on the memory's valid cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_owner_dm <= 1'b0;
            r_last_dm  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_grant) begin
                r_owner_dm <= w_grant_dm;
                r_last_dm  <= w_grant_dm;
                r_we       <= w_grant_dm & i_dm_we;
                r_addr     <= w_grant_dm ? i_dm_addr : i_if_addr;
                r_wdata    <= i_dm_wdata;
            end
            if (r_state == ISSUE)
                r_cnt <= LAT_M1;
            else if (r_state == WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_last && !r_we) begin
                if (r_owner_dm) r_dm_rdata <= i_mem_rdata;
                else            r_if_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_we    = o_mem_en & r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_stall_if  = i_if_req & ~o_if_valid;
    assign o_stall_mem = i_dm_req & ~o_dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench; three arbiters (MEM_LAT 2, 1, 15) share the stimulus
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        bit          dm;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata [3];
    logic [DW-1:0] dm_rdata [3];
    logic [DW-1:0] mem_wdata[3];
    logic [DW-1:0] mem_rdata[3];
    logic [AW-1:0] mem_addr [3];
    logic          if_valid [3];
    logic          dm_valid [3];
    logic          stall_if [3];
    logic          stall_mem[3];
    logic          mem_en   [3];
    logic          mem_we   [3];

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] dflt(input logic [4:0] a);
        logic [4:0] s;
        s = a + 5'd2;
        return {16'h2002, 11'd0, s};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic [DW-1:0]        mem [32];
        logic [31:0]          wr;
        logic [15:0]          vp = '0;
        logic [15:0][DW-1:0]  dp = '0;

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_if_req(if_req), .i_if_addr(if_addr),
            .o_if_rdata(if_rdata[g]), .o_if_valid(if_valid[g]),
            .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
            .o_dm_rdata(dm_rdata[g]), .o_dm_valid(dm_valid[g]),
            .o_stall_if(stall_if[g]), .o_stall_mem(stall_mem[g]),
            .o_mem_en(mem_en[g]), .o_mem_we(mem_we[g]),
            .o_mem_addr(mem_addr[g]), .o_mem_wdata(mem_wdata[g]),
            .i_mem_rdata(mem_rdata[g])
        );

        // memory: read data is driven only in the cycle exactly L cycles after mem_en
        always @(posedge clk) begin
            if (!rst_n) wr <= '0;
            else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g]] <= mem_wdata[g];
                wr[mem_addr[g]]  <= 1'b1;
            end
            vp <= {vp[14:0], mem_en[g] & ~mem_we[g]};
            dp <= {dp[14:0], wr[mem_addr[g]] ? mem[mem_addr[g]] : dflt(mem_addr[g])};
        end
        assign mem_rdata[g] = vp[L-1] ? dp[L-1] : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit dm, input logic [31:0] d);
        q.push_back('{dm: dm, data: d});
    endtask

    task automatic sb();
        exp_t e;
        if (if_valid[0] || dm_valid[0]) begin
            if (q.size() == 0) chk("sb_extra_valid", 32'({if_valid[0], dm_valid[0]}), 32'd0);
            else begin
                e = q.pop_front();
                chk("sb_port", 32'(dm_valid[0]), 32'(e.dm));
                chk("sb_data", e.dm ? dm_rdata[0] : if_rdata[0], e.data);
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        sb();
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int r = 0; r < 2; r++) begin
            pos(); neg();
            chk("rst_stall_if", 32'(stall_if[0]), 32'd1);
            chk("rst_stall_mem", 32'(stall_mem[0]), 32'd0);
            chk("rst_valid", 32'({if_valid[0], dm_valid[0]}), 32'd0);
            chk("rst_mem_en", 32'({mem_en[0], mem_en[1], mem_en[2], mem_we[0]}), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
            chk("rst_mem_wdata", mem_wdata[0], 32'd0);
            chk("rst_rdata", if_rdata[0] | dm_rdata[0], 32'd0);
        end
        pos(); rst_n = 1'b1; if_req = 1'b0; neg();

        // single IF read of word 3
        pos(); if_req = 1'b1; if_addr = 5'd3; push(1'b0, 32'h2002_0005); neg();
        chk("if_c0_stall", 32'(stall_if[0]), 32'd1);
        chk("if_c0_en", 32'(mem_en[0]), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            pos(); if (c == 1) if_addr = 5'd9; neg();
            chk("if_en", 32'(mem_en[0]), 32'(c == 1));
            chk("if_valid", 32'(if_valid[0]), 32'(c == 4));
            chk("if_stall", 32'(stall_if[0]), 32'(c != 4));
            chk("if_we_addr", 32'({mem_we[0], mem_addr[0]}), 32'd3);
            if (c == 4) chk("if_rdata", if_rdata[0], 32'h2002_0005);
        end
        pos(); if_req = 1'b0; neg();
        chk("if_rdata_hold", if_rdata[0], 32'h2002_0005);

        // conflict: both held, grants alternate DM, IF, DM, IF
        pos(); if_req = 1'b1; dm_req = 1'b1; if_addr = 5'd12; dm_addr = 5'd10; dm_we = 1'b0;
        push(1'b1, dflt(5'd10)); push(1'b0, dflt(5'd12)); neg();
        for (int c = 1; c <= 19; c++) begin
            pos();
            if (c == 10) begin
                if_addr = 5'd13;
                push(1'b1, dflt(5'd10)); push(1'b0, dflt(5'd13));
            end
            neg();
            chk("cf_if_valid", 32'(if_valid[0]), 32'(c == 9 || c == 19));
            chk("cf_dm_valid", 32'(dm_valid[0]), 32'(c == 4 || c == 14));
            chk("cf_stall_if", 32'(stall_if[0]), 32'(c != 9 && c != 19));
            chk("cf_stall_mem", 32'(stall_mem[0]), 32'(c != 4 && c != 14));
        end
        pos(); if_req = 1'b0; dm_req = 1'b0; neg();

        // DM write 0xDEADBEEF to word 7, then read it back
        pos(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5'd7; dm_wdata = 32'hDEAD_BEEF;
        push(1'b1, dflt(5'd10)); neg();
        for (int c = 1; c <= 9; c++) begin
            pos();
            if (c == 1) begin dm_wdata = 32'h1234_5678; dm_addr = 5'd1; end
            if (c == 5) begin dm_we = 1'b0; dm_addr = 5'd7; push(1'b1, 32'hDEAD_BEEF); end
            neg();
            chk("wr_dm_valid", 32'(dm_valid[0]), 32'(c == 4 || c == 9));
            chk("wr_mem_en", 32'(mem_en[0]), 32'(c == 1 || c == 6));
            chk("wr_mem_we", 32'(mem_we[0]), 32'(c == 1));
            if (c <= 5) chk("wr_mem_addr", 32'(mem_addr[0]), 32'd7);
            if (c <= 5) chk("wr_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
            if (c == 4) chk("wr_rdata_keep", dm_rdata[0], dflt(5'd10));
            if (c == 6) chk("rd_mem_addr", 32'(mem_addr[0]), 32'd7);
        end
        pos(); dm_req = 1'b0; neg();

        // reset during WAIT abandons the access
        pos(); rst_n = 1'b0; neg();
        pos(); rst_n = 1'b1; neg();
        pos(); if_req = 1'b1; if_addr = 5'd4; neg();
        for (int c = 1; c <= 9; c++) begin
            pos();
            if (c == 1) if_req = 1'b0;
            if (c == 2) rst_n = 1'b0;
            if (c == 3) rst_n = 1'b1;
            neg();
            if (c == 1) chk("mr_en_issue", 32'(mem_en[0]), 32'd1);
            if (c >= 3) chk("mr_en_low", 32'({mem_en[0], mem_en[1], mem_en[2]}), 32'd0);
            if (c >= 3) chk("mr_no_valid", 32'({if_valid[0], if_valid[1], if_valid[2]}), 32'd0);
        end
        chk("mr_rdata0", if_rdata[0], 32'd0);
        chk("mr_rdata1", if_rdata[1], 32'd0);

        // latency sweep with the IF request dropped right after grant
        pos(); if_req = 1'b1; if_addr = 5'd20; push(1'b0, dflt(5'd20)); neg();
        for (int c = 1; c <= 19; c++) begin
            pos(); if (c == 1) if_req = 1'b0; neg();
            for (int u = 0; u < 3; u++) begin
                int vc;
                vc = (u == 0) ? 4 : (u == 1) ? 3 : 17;
                chk($sformatf("sw%0d_valid", u), 32'(if_valid[u]), 32'(c == vc));
                chk($sformatf("sw%0d_en", u), 32'(mem_en[u]), 32'(c == 1));
                if (c == vc) chk($sformatf("sw%0d_rdata", u), if_rdata[u], dflt(5'd20));
            end
        end

        // DM read with request dropped one cycle after grant
        pos(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 5'd11; push(1'b1, dflt(5'd11)); neg();
        for (int c = 1; c <= 5; c++) begin
            pos(); if (c == 1) dm_req = 1'b0; neg();
            chk("dd_valid", 32'(dm_valid[0]), 32'(c == 4));
            chk("dd_stall", 32'(stall_mem[0]), 32'd0);
        end

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single shared, non-pipelined, fixed-latency word memory that serves both the instruction-fetch port and the data-memory port of the 5-stage pipeline. It accepts one request at a time, resolves IF/DM conflicts, drives the memory control signals, returns read data with a one-cycle valid pulse, and generates per-port stall signals. The pipeline uses these stall signals to freeze the PC, IF/ID and later stages while an access is pending.

## Interface
- ADDR_W, 5, word-address width; matches the 32-word memories.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_valid is high.
- dm_valid  out  1  one-cycle completion pulse for DM, for both reads and writes.
- stall_if  out  1  equals if_req & ~if_valid.
- stall_mem  out  1  equals dm_req & ~dm_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester active: grant it.
  - Both active: grant DM unless the previous grant was DM, in which case grant IF. This alternation prevents starvation.
  - On grant: latch owner, address, we (forced 0 for IF) and wdata into mem_addr/mem_we/mem_wdata; go to ISSUE.
- ISSUE: mem_en=1 and mem_we=latched we, for exactly one cycle. Load the wait counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - Counter nonzero: decrement and stay.
  - Counter zero: this is the mem_rdata-valid cycle. Capture mem_rdata into the owner's rdata register (reads only; for writes dm_rdata keeps its old value). Go to DONE.
- DONE: pulse the owner's valid for one cycle; always go to IDLE. The owner's request in the DONE cycle is never re-granted; a request still high in the next IDLE cycle is a new access.
- mem_addr, mem_we and mem_wdata hold their values from grant until the next grant. mem_we is gated so it is 0 whenever mem_en is 0.
- A request dropped after grant does not abort the access: it runs to completion and its valid pulse is still produced.
- Inputs sampled only at grant; later changes to addr/wdata/we are ignored for the access in flight.
- if_rdata and dm_rdata hold their last captured value between accesses.

## Timing
- Reset (Reset=0 at a rising edge):
  - State = IDLE; the last-grant flag selects IF, so DM wins the first conflict.
  - mem_en, mem_we, if_valid, dm_valid = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - stall_* therefore follow the request inputs directly.
- Reset mid-access: the access is abandoned with no valid pulse. mem_en is low from the next cycle, and late mem_rdata is ignored.
- Timeline for a request seen in IDLE at cycle 0:
  - Cycle 1: ISSUE, mem_en=1.
  - Cycle 1+MEM_LAT: capture of mem_rdata.
  - Cycle 2+MEM_LAT: valid=1.
  - Request-to-valid latency = MEM_LAT+2 cycles.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- stall_* are combinational from registered valid and the request inputs. No combinational path exists from mem_rdata to any output.
- Simultaneous requests: the loser keeps its stall high through the winner's whole access plus its own access.

## Test plan
- Reset: drive Reset=0 for 2 cycles with if_req=1. Required: all outputs 0 except stall_if=1; no mem_en pulse.
- Single IF read, MEM_LAT=2, memory word 3 = 0x2002_0005: assert if_req, if_addr=3 at cycle 0.
  - Required: mem_en=1 only in cycle 1 with mem_addr=3 and mem_we=0.
  - Required: if_valid=1 and if_rdata=0x2002_0005 in cycle 4; stall_if=1 in cycles 0-3 and 0 in cycle 4.
- DM write then read: store 0xDEAD_BEEF to address 7, then load address 7.
  - Required: write has mem_we=1 with mem_en, and dm_valid at cycle 4.
  - Required: dm_rdata is unchanged on the write's dm_valid.
  - Required: the second grant comes at cycle 5, with dm_valid and dm_rdata=0xDEAD_BEEF at cycle 9.
- Conflict and alternation: hold if_req and dm_req together from cycle 0.
  - Required: DM is served first (valid at cycle 4), then IF (valid at cycle 9).
  - Re-assert both for further accesses: grants continue to alternate.
- Reset mid-access: assert Reset=0 during WAIT. Required: no valid pulse, and mem_en stays 0 until a new grant after reset.
- Dropped request and latency sweep:
  - Drop dm_req one cycle after grant. Required: dm_valid still pulses at cycle 4.
  - Repeat the single IF read with MEM_LAT=1 and MEM_LAT=15. Required: valid at cycle 3 and cycle 17 respectively.
